// File: rtl/wb_stage.sv
// -----------------------------------------------------------------------------
// wb_stage : write-back stage of the streamline CPU.
//
// This stage sits directly after the MEM/WB pipeline register. It:
//   - chooses the write-back value (link address, LUI immediate, RAM data or
//     ALU result),
//   - holds the 32 x 32-bit register file, which has two asynchronous read
//     ports with same-cycle write-through for the ID stage,
//   - owns the sticky halt flag and the retired-instruction and cycle counters.
//
// Ports
//   clk, rst                 clock (rising edge), asynchronous active-high reset
//   valid_i                  MEM/WB holds a real instruction (0 = bubble)
//   halt_i                   instruction in MEM/WB is a halt
//   rw_i                     destination register index
//   jal_i                    write PC_i+PC_STEP to LINK_REG
//   MemToReg_i, lui_i        write-back source select
//   Regwrite_i               register write enable
//   Imm_i, PC_i, ALU_i, Ram_i  operand sources
//   ra1_i, ra2_i             read addresses from ID
//   rd1_o, rd2_o             read data (combinational)
//   wb_en_o, wb_rw_o, wb_data_o  effective write this cycle (combinational)
//   halt_o                   sticky halt flag (registered)
//   retired_o, cycles_o      statistics counters (registered)
// -----------------------------------------------------------------------------
module wb_stage #(
    parameter int PC_STEP  = 1,
    parameter int LINK_REG = 31,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    input  logic             halt_i,
    input  logic [4:0]       rw_i,
    input  logic             jal_i,
    input  logic             MemToReg_i,
    input  logic             Regwrite_i,
    input  logic             lui_i,
    input  logic [31:0]      Imm_i,
    input  logic [31:0]      PC_i,
    input  logic [31:0]      ALU_i,
    input  logic [31:0]      Ram_i,
    input  logic [4:0]       ra1_i,
    input  logic [4:0]       ra2_i,
    output logic [31:0]      rd1_o,
    output logic [31:0]      rd2_o,
    output logic             wb_en_o,
    output logic [4:0]       wb_rw_o,
    output logic [31:0]      wb_data_o,
    output logic             halt_o,
    output logic [CNT_W-1:0] retired_o,
    output logic [CNT_W-1:0] cycles_o
);

    logic             halt_reg;
    logic [CNT_W-1:0] retired_reg;
    logic [CNT_W-1:0] cycles_reg;
    logic [31:0]      rf_reg [0:31];

    // ------------------------------------------------------------------
    // Write-back source selection and effective write
    // ------------------------------------------------------------------
    always_comb begin
        wb_data_o = ALU_i;
        if (jal_i) begin
            wb_data_o = PC_i + 32'(PC_STEP);
        end else if (lui_i) begin
            wb_data_o = {Imm_i[15:0], 16'h0000};
        end else if (MemToReg_i) begin
            wb_data_o = Ram_i;
        end
    end

    assign wb_rw_o = jal_i ? 5'(LINK_REG) : rw_i;

    // Once halted nothing more is written; $0 is never a real target.
    assign wb_en_o = valid_i & (Regwrite_i | jal_i) & ~halt_reg & (wb_rw_o != 5'd0);

    // ------------------------------------------------------------------
    // Register file: one flop word per register so the asynchronous reset
    // can clear all of them at once. Entry 0 is only ever reset, so it
    // always holds zero and needs no special case on the read side.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_rf
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rf_reg[gi] <= '0;
                end else if (wb_en_o && (wb_rw_o == 5'(gi))) begin
                    rf_reg[gi] <= wb_data_o;
                end
            end
        end
    endgenerate

    // Read ports: forward the value being written this cycle so ID sees it
    // without an extra bubble. While reset is held both ports read zero.
    always_comb begin
        rd1_o = '0;
        if (!rst) begin
            if (wb_en_o && (ra1_i == wb_rw_o)) begin
                rd1_o = wb_data_o;
            end else begin
                rd1_o = rf_reg[ra1_i];
            end
        end
    end

    always_comb begin
        rd2_o = '0;
        if (!rst) begin
            if (wb_en_o && (ra2_i == wb_rw_o)) begin
                rd2_o = wb_data_o;
            end else begin
                rd2_o = rf_reg[ra2_i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Halt flag and statistics counters. The edge that raises the halt flag
    // still counts both the cycle and the halt instruction itself.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            halt_reg    <= 1'b0;
            retired_reg <= '0;
            cycles_reg  <= '0;
        end else if (!halt_reg) begin
            cycles_reg <= cycles_reg + CNT_W'(1);
            if (valid_i) begin
                retired_reg <= retired_reg + CNT_W'(1);
                if (halt_i) begin
                    halt_reg <= 1'b1;
                end
            end
        end
    end

    assign halt_o    = halt_reg;
    assign retired_o = retired_reg;
    assign cycles_o  = cycles_reg;

endmodule

// File: tb/tb_wb_stage.sv
// -----------------------------------------------------------------------------
// tb_wb_stage : directed testbench for wb_stage.
// Each task drives one scenario and checks its results inline against
// hand-computed values.
// -----------------------------------------------------------------------------
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_i, halt_i, jal_i, MemToReg_i, Regwrite_i, lui_i;
    logic [4:0]  rw_i, ra1_i, ra2_i;
    logic [31:0] Imm_i, PC_i, ALU_i, Ram_i;
    logic [31:0] rd1_o, rd2_o, wb_data_o;
    logic        wb_en_o, halt_o;
    logic [4:0]  wb_rw_o;
    logic [31:0] retired_o, cycles_o;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    wb_stage #(.PC_STEP(1), .LINK_REG(31), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .valid_i(valid_i), .halt_i(halt_i), .rw_i(rw_i), .jal_i(jal_i),
        .MemToReg_i(MemToReg_i), .Regwrite_i(Regwrite_i), .lui_i(lui_i),
        .Imm_i(Imm_i), .PC_i(PC_i), .ALU_i(ALU_i), .Ram_i(Ram_i),
        .ra1_i(ra1_i), .ra2_i(ra2_i), .rd1_o(rd1_o), .rd2_o(rd2_o),
        .wb_en_o(wb_en_o), .wb_rw_o(wb_rw_o), .wb_data_o(wb_data_o),
        .halt_o(halt_o), .retired_o(retired_o), .cycles_o(cycles_o)
    );

    always #5 clk = ~clk;

    task automatic idle();
        valid_i = 0; halt_i = 0; jal_i = 0; MemToReg_i = 0; Regwrite_i = 0; lui_i = 0;
        rw_i = 0; ra1_i = 0; ra2_i = 0; Imm_i = 0; PC_i = 0; ALU_i = 0; Ram_i = 0;
    endtask

    // Applies the current inputs across one rising edge, then settles 1 ns.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        $display("cycle %0d: valid=%0b halt_i=%0b rw=%0d en=%0b data=%h halt_o=%0b ret=%0d cyc=%0d",
                 cyc, valid_i, halt_i, wb_rw_o, wb_en_o, wb_data_o, halt_o, retired_o, cycles_o);
    endtask

    task automatic write_alu(input logic [4:0] rw, input logic [31:0] val);
        idle();
        valid_i = 1; Regwrite_i = 1; rw_i = rw; ALU_i = val;
        step();
    endtask

    task automatic test_reset();
        idle();
        #2;
        n_vec++; if (halt_o !== 1'b0) begin n_err++; $display("FAIL reset_halt: got %b want 0", halt_o); end
        n_vec++; if (retired_o !== 32'd0) begin n_err++; $display("FAIL reset_retired: got %0d want 0", retired_o); end
        n_vec++; if (cycles_o !== 32'd0) begin n_err++; $display("FAIL reset_cycles: got %0d want 0", cycles_o); end
        repeat (2) @(posedge clk);
        #2 rst = 0;
    endtask

    task automatic test_alu_write();
        idle();
        valid_i = 1; Regwrite_i = 1; rw_i = 5; ALU_i = 32'h1234;
        #1;
        n_vec++; if (wb_en_o !== 1'b1 || wb_data_o !== 32'h1234)
            begin n_err++; $display("FAIL alu_comb: got en=%b data=%h want 1 00001234", wb_en_o, wb_data_o); end
        step();
        idle(); ra1_i = 5;
        #1;
        n_vec++; if (rd1_o !== 32'h1234) begin n_err++; $display("FAIL alu_rd1: got %h want 00001234", rd1_o); end
        n_vec++; if (retired_o !== 32'd1) begin n_err++; $display("FAIL alu_retired: got %0d want 1", retired_o); end
        n_vec++; if (cycles_o !== 32'd1) begin n_err++; $display("FAIL alu_cycles: got %0d want 1", cycles_o); end
    endtask

    task automatic test_priority();
        idle();
        valid_i = 1; jal_i = 1; lui_i = 1; MemToReg_i = 1; rw_i = 3; PC_i = 100; Imm_i = 32'h1111; Ram_i = 55; ALU_i = 66;
        #1;
        n_vec++; if (wb_rw_o !== 5'd31 || wb_en_o !== 1'b1)
            begin n_err++; $display("FAIL jal_dest: got rw=%0d en=%b want 31 1", wb_rw_o, wb_en_o); end
        step();
        idle();
        valid_i = 1; Regwrite_i = 1; lui_i = 1; MemToReg_i = 1; Imm_i = 32'h0000ABCD; rw_i = 3; Ram_i = 55;
        step();
        idle();
        valid_i = 1; Regwrite_i = 1; MemToReg_i = 1; Ram_i = 7; ALU_i = 99; rw_i = 4;
        step();
        idle(); ra1_i = 31; ra2_i = 3;
        #1;
        n_vec++; if (rd1_o !== 32'd101) begin n_err++; $display("FAIL jal_link: got %0d want 101", rd1_o); end
        n_vec++; if (rd2_o !== 32'hABCD0000) begin n_err++; $display("FAIL lui_val: got %h want abcd0000", rd2_o); end
        ra1_i = 4;
        #1;
        n_vec++; if (rd1_o !== 32'd7) begin n_err++; $display("FAIL mem_val: got %0d want 7", rd1_o); end
    endtask

    task automatic test_write_through();
        idle();
        valid_i = 1; Regwrite_i = 1; rw_i = 8; ALU_i = 32'hDEAD; ra1_i = 8; ra2_i = 8;
        #1;
        n_vec++; if (rd1_o !== 32'hDEAD || rd2_o !== 32'hDEAD)
            begin n_err++; $display("FAIL write_through: got %h %h want 0000dead 0000dead", rd1_o, rd2_o); end
        step();
        idle();
        valid_i = 1; Regwrite_i = 1; rw_i = 0; ALU_i = 5; ra1_i = 0;
        #1;
        n_vec++; if (wb_en_o !== 1'b0 || rd1_o !== 32'd0)
            begin n_err++; $display("FAIL r0_comb: got en=%b rd1=%h want 0 0", wb_en_o, rd1_o); end
        step();
        idle(); ra1_i = 0; ra2_i = 8;
        #1;
        n_vec++; if (rd1_o !== 32'd0 || rd2_o !== 32'hDEAD)
            begin n_err++; $display("FAIL r0_stored: got %h %h want 0 0000dead", rd1_o, rd2_o); end
    endtask

    task automatic test_bubble();
        logic [31:0] ret0, cyc0;
        write_alu(2, 32'h22);
        idle();
        ret0 = retired_o; cyc0 = cycles_o;
        valid_i = 0; Regwrite_i = 1; rw_i = 2; ALU_i = 32'h77;
        step();
        idle(); ra1_i = 2;
        #1;
        n_vec++; if (rd1_o !== 32'h22) begin n_err++; $display("FAIL bubble_reg: got %h want 00000022", rd1_o); end
        n_vec++; if (retired_o !== ret0) begin n_err++; $display("FAIL bubble_retired: got %0d want %0d", retired_o, ret0); end
        n_vec++; if (cycles_o !== cyc0 + 32'd1) begin n_err++; $display("FAIL bubble_cycles: got %0d want %0d", cycles_o, cyc0 + 32'd1); end
    endtask

    task automatic test_halt();
        idle();
        @(negedge clk) rst = 1;
        #2 rst = 0;
        write_alu(11, 11);
        write_alu(12, 12);
        write_alu(13, 13);
        idle();
        valid_i = 1; halt_i = 1; Regwrite_i = 1; rw_i = 9; ALU_i = 9;
        #1;
        n_vec++; if (wb_en_o !== 1'b1) begin n_err++; $display("FAIL halt_commit_en: got %b want 1", wb_en_o); end
        step();
        n_vec++; if (halt_o !== 1'b1) begin n_err++; $display("FAIL halt_set: got %b want 1", halt_o); end
        idle();
        valid_i = 1; Regwrite_i = 1; rw_i = 10; ALU_i = 10;
        #1;
        n_vec++; if (wb_en_o !== 1'b0) begin n_err++; $display("FAIL halt_block_en: got %b want 0", wb_en_o); end
        step();
        halt_i = 1;
        step();
        idle(); ra1_i = 9; ra2_i = 10;
        #1;
        n_vec++; if (rd1_o !== 32'd9 || rd2_o !== 32'd0)
            begin n_err++; $display("FAIL halt_regs: got r9=%0d r10=%0d want 9 0", rd1_o, rd2_o); end
        n_vec++; if (retired_o !== 32'd4 || cycles_o !== 32'd4)
            begin n_err++; $display("FAIL halt_counters: got ret=%0d cyc=%0d want 4 4", retired_o, cycles_o); end
        n_vec++; if (halt_o !== 1'b1) begin n_err++; $display("FAIL halt_sticky: got %b want 1", halt_o); end
    endtask

    task automatic test_async_reset();
        idle(); ra1_i = 9; ra2_i = 13;
        @(posedge clk);
        #3 rst = 1;
        #1;
        n_vec++; if (halt_o !== 1'b0 || retired_o !== 32'd0 || cycles_o !== 32'd0)
            begin n_err++; $display("FAIL async_state: got halt=%b ret=%0d cyc=%0d want 0 0 0", halt_o, retired_o, cycles_o); end
        n_vec++; if (rd1_o !== 32'd0 || rd2_o !== 32'd0)
            begin n_err++; $display("FAIL async_rd_in_rst: got %h %h want 0 0", rd1_o, rd2_o); end
        rst = 0;
        #0.5;
        n_vec++; if (rd1_o !== 32'd0 || rd2_o !== 32'd0)
            begin n_err++; $display("FAIL async_regs_cleared: got %h %h want 0 0", rd1_o, rd2_o); end
        step();
        n_vec++; if (cycles_o !== 32'd1) begin n_err++; $display("FAIL async_restart: got %0d want 1", cycles_o); end
    endtask

    initial begin
        idle();
        test_reset();
        test_alu_write();
        test_priority();
        test_write_through();
        test_bubble();
        test_halt();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation exceeded 20000 ns");
        $fatal(1, "timeout");
    end

endmodule
